// File: rtl/adj_rr_scheduler.sv
// Round-robin front end for a shared multi-cycle posit normalization engine:
// arbitrates requesters, launches the engine, bypasses zeros, and watchdogs hangs.
module adj_rr_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 80
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*10-1:0]         req_scale,
  input  logic [NREQ*64-1:0]         req_mant,
  output logic                       eng_start,
  output logic [9:0]                 eng_scale_in,
  output logic [63:0]                eng_mant_prod,
  output logic                       eng_rst_n,
  input  logic                       eng_done,
  input  logic [9:0]                 eng_scale_out,
  input  logic [63:0]                eng_mant_adj,
  input  logic [63:0]                eng_shift_amt,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [9:0]                 rsp_scale,
  output logic [63:0]                rsp_mant,
  output logic [6:0]                 rsp_shift,
  output logic                       rsp_zero,
  output logic                       rsp_timeout
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned SW  = IDW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT);
  localparam int unsigned SCW = 10;
  localparam int unsigned MW  = 64;
  localparam int unsigned SHW = 7;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e           state_q;
  logic [IDW-1:0]   last_grant_q;
  logic [IDW-1:0]   id_q;
  logic [WDW-1:0]   wdog_q;
  logic             eng_start_q;
  logic [SCW-1:0]   eng_scale_q;
  logic [MW-1:0]    eng_mant_q;
  logic             kill_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [SCW-1:0]   rsp_scale_q;
  logic [MW-1:0]    rsp_mant_q;
  logic [SHW-1:0]   rsp_shift_q;
  logic             rsp_zero_q;
  logic             rsp_timeout_q;

  logic             found_c;
  logic [IDW-1:0]   gid_c;
  logic [SW-1:0]    idx_c;
  logic [SCW-1:0]   sel_scale_c;
  logic [MW-1:0]    sel_mant_c;
  logic             unused_shift_hi;

  // First valid requester after last_grant, wrapping; smallest offset wins.
  always_comb begin
    found_c = 1'b0;
    gid_c   = '0;
    idx_c   = '0;
    for (int off = int'(NREQ); off >= 1; off--) begin
      idx_c = {1'b0, last_grant_q} + SW'(off);
      if (idx_c >= SW'(NREQ)) idx_c = idx_c - SW'(NREQ);
      if (req_valid[idx_c[IDW-1:0]]) begin
        found_c = 1'b1;
        gid_c   = idx_c[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_scale_c = '0;
    sel_mant_c  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == gid_c) begin
        sel_scale_c = req_scale[i*SCW +: SCW];
        sel_mant_c  = req_mant[i*MW +: MW];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE && found_c) ? (NREQ'(1) << gid_c) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= IDW'(NREQ - 1);
      id_q          <= '0;
      wdog_q        <= '0;
      eng_start_q   <= 1'b0;
      eng_scale_q   <= '0;
      eng_mant_q    <= '0;
      kill_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_scale_q   <= '0;
      rsp_mant_q    <= '0;
      rsp_shift_q   <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      kill_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found_c) begin
            last_grant_q <= gid_c;
            id_q         <= gid_c;
            if (sel_mant_c == '0) begin
              // Engine cannot normalize zero; answer directly.
              rsp_valid_q <= 1'b1;
              rsp_zero_q  <= 1'b1;
              rsp_id_q    <= gid_c;
              state_q     <= S_RESP;
            end else begin
              eng_scale_q <= sel_scale_c;
              eng_mant_q  <= sel_mant_c;
              eng_start_q <= 1'b1;
              state_q     <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + WDW'(1);
          if (eng_done) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_scale_q <= eng_scale_out;
            rsp_mant_q  <= eng_mant_adj;
            rsp_shift_q <= eng_shift_amt[SHW-1:0];
            state_q     <= S_RESP;
          end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
            // Hung engine: report, and reset it for one cycle.
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= id_q;
            rsp_timeout_q <= 1'b1;
            kill_q        <= 1'b1;
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_scale_q   <= '0;
            rsp_mant_q    <= '0;
            rsp_shift_q   <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng_start       = eng_start_q;
  assign eng_scale_in    = eng_scale_q;
  assign eng_mant_prod   = eng_mant_q;
  assign eng_rst_n       = rst_n & ~kill_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_scale       = rsp_scale_q;
  assign rsp_mant        = rsp_mant_q;
  assign rsp_shift       = rsp_shift_q;
  assign rsp_zero        = rsp_zero_q;
  assign rsp_timeout     = rsp_timeout_q;
  assign unused_shift_hi = ^eng_shift_amt[63:SHW];

endmodule

// File: tb/tb_adj_rr_scheduler.sv
// Scoreboard bench for adj_rr_scheduler: behavioural engine, round-robin
// reference model, and a decoupled response monitor.
module tb_adj_rr_scheduler;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 80;
  localparam int M_NORM  = 0;
  localparam int M_HANG  = 1;
  localparam int M_EXP   = 2;

  typedef struct {
    int          id;
    logic [9:0]  scale;
    logic [63:0] mant;
    logic [6:0]  shift;
    bit          zero;
    bit          tmo;
    int          lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*10-1:0] req_scale;
  logic [NREQ*64-1:0] req_mant;
  logic              eng_start;
  logic [9:0]        eng_scale_in;
  logic [63:0]       eng_mant_prod;
  logic              eng_rst_n;
  logic              eng_done = 1'b0;
  logic [9:0]        eng_scale_out = '0;
  logic [63:0]       eng_mant_adj = '0;
  logic [63:0]       eng_shift_amt = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [1:0]        rsp_id;
  logic [9:0]        rsp_scale;
  logic [63:0]       rsp_mant;
  logic [6:0]        rsp_shift;
  logic              rsp_zero;
  logic              rsp_timeout;

  adj_rr_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_scale(req_scale), .req_mant(req_mant),
    .eng_start(eng_start), .eng_scale_in(eng_scale_in), .eng_mant_prod(eng_mant_prod),
    .eng_rst_n(eng_rst_n), .eng_done(eng_done), .eng_scale_out(eng_scale_out),
    .eng_mant_adj(eng_mant_adj), .eng_shift_amt(eng_shift_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_scale(rsp_scale), .rsp_mant(rsp_mant), .rsp_shift(rsp_shift),
    .rsp_zero(rsp_zero), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   eng_mode = M_NORM;
  int   model_lg = NREQ - 1;
  int   exp_starts = 0;
  int   exp_kills = 0;
  int   starts = 0;
  int   kills = 0;
  bit   rand_rdy = 1'b0;
  bit   stall_next = 1'b0;
  int   hold_low = 0;
  exp_t exp_q[$];
  int   grant_q[$];
  int   acc_q[$];
  logic [9:0]  b_scale [NREQ];
  logic [63:0] b_mant  [NREQ];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", nm, cyc, act, req);
    end
  endtask

  // Ideal normalization: bring the leading one to bit 62.
  task automatic norm(input logic [9:0] sc, input logic [63:0] m,
                      output logic [9:0] os, output logic [63:0] om, output int k);
    if (m[63]) begin
      om = m >> 1;
      os = sc + 10'd1;
      k  = 1;
    end else begin
      k = 0;
      while (k < 62 && m[62-k] == 1'b0) k++;
      om = m << k;
      os = sc - 10'(k);
    end
  endtask

  task automatic model(input int id, input logic [9:0] sc, input logic [63:0] m, output exp_t e);
    logic [9:0]  os;
    logic [63:0] om;
    int          k;
    e.id = id; e.scale = '0; e.mant = '0; e.shift = '0; e.zero = 0; e.tmo = 0; e.lat = 0;
    if (m == 64'd0) begin
      e.zero = 1;
      e.lat  = 1;
    end else begin
      exp_starts++;
      if (eng_mode == M_HANG) begin
        e.tmo = 1;
        e.lat = TIMEOUT + 2;
        exp_kills++;
      end else begin
        norm(sc, m, os, om, k);
        e.scale = os;
        e.mant  = om;
        e.shift = 7'(k);
        e.lat   = (eng_mode == M_EXP) ? TIMEOUT + 2 : 5 + k;
      end
    end
  endtask

  function automatic logic [63:0] rand_mant();
    int          r;
    int          lz;
    logic [63:0] m;
    r = $urandom_range(0, 9);
    m = {$urandom, $urandom};
    lz = $urandom_range(0, 62);
    if (r == 0) return 64'd0;
    if (r == 1) return m | 64'h8000_0000_0000_0000;
    return (m >> (lz + 2)) | (64'h1 << (62 - lz));
  endfunction

  // Behavioural engine: done 3+k cycles after start, or never, or at watchdog expiry.
  logic [9:0]  e_ns;
  logic [63:0] e_nm;
  int          e_nk;
  int          e_cnt = 0;
  bit          e_busy = 0;
  always @(posedge clk or negedge eng_rst_n) begin
    if (!eng_rst_n) begin
      e_busy   <= 0;
      e_cnt    <= 0;
      eng_done <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start) begin
        norm(eng_scale_in, eng_mant_prod, e_ns, e_nm, e_nk);
        eng_scale_out <= e_ns;
        eng_mant_adj  <= e_nm;
        eng_shift_amt <= 64'(e_nk);
        e_busy        <= (eng_mode != M_HANG);
        e_cnt         <= (eng_mode == M_EXP) ? TIMEOUT - 1 : 2 + e_nk;
      end else if (e_busy) begin
        if (e_cnt == 1) begin
          eng_done <= 1'b1;
          e_busy   <= 0;
        end else begin
          e_cnt <= e_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (hold_low > 0) begin
      rsp_ready = 1'b0;
      hold_low--;
    end else if (stall_next && rsp_valid) begin
      rsp_ready  = 1'b0;
      hold_low   = 9;
      stall_next = 0;
    end else begin
      rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Response monitor: pops the scoreboard on each new response.
  exp_t cur;
  bit   tracking = 0;
  bit   prev_start = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      tracking   = 0;
      prev_start = 0;
    end else begin
      if (eng_start) begin
        starts++;
        chk("start_pulse_width", prev_start, 0);
      end
      prev_start = eng_start;
      if (!eng_rst_n) kills++;
      if (rsp_valid) begin
        if (!tracking) begin
          tracking = 1;
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            chk("unexpected_rsp", rsp_valid, 0);
            cur.id = 0; cur.scale = '0; cur.mant = '0; cur.shift = '0;
            cur.zero = 0; cur.tmo = 0; cur.lat = 0;
          end else begin
            cur = exp_q.pop_front();
            chk("latency", cyc - acc_q.pop_front(), cur.lat);
            chk("eng_rst_n_at_resp", eng_rst_n, !cur.tmo);
          end
          chk("rsp_id", rsp_id, cur.id);
          chk("rsp_scale", rsp_scale, cur.scale);
          chk("rsp_mant", rsp_mant, cur.mant);
          chk("rsp_shift", rsp_shift, cur.shift);
          chk("rsp_zero", rsp_zero, cur.zero);
          chk("rsp_timeout", rsp_timeout, cur.tmo);
        end else begin
          chk("rsp_held", {rsp_id, rsp_scale, rsp_mant, rsp_shift, rsp_zero, rsp_timeout},
              {2'(cur.id), cur.scale, cur.mant, cur.shift, cur.zero, cur.tmo});
        end
        chk("no_ready_in_resp", req_ready, 0);
        if (rsp_ready) tracking = 0;
      end
    end
  end

  // Predict the grant order for a set of one-shot requests, then drive them.
  task automatic issue_batch(input logic [NREQ-1:0] set);
    exp_t            e;
    int              base;
    int              idx;
    int              budget;
    logic [NREQ-1:0] acc;
    base = model_lg;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (base + off) % NREQ;
      if (set[idx]) begin
        model(idx, b_scale[idx], b_mant[idx], e);
        exp_q.push_back(e);
        grant_q.push_back(idx);
        model_lg = idx;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      req_scale[i*10 +: 10] = b_scale[i];
      req_mant[i*64 +: 64]  = b_mant[i];
    end
    req_valid = set;
    budget = 3000;
    while (req_valid != '0 && budget > 0) begin
      @(negedge clk);
      budget--;
      acc = req_valid & req_ready;
      if (acc != '0) begin
        if (grant_q.size() == 0) chk("grant_extra", acc, 0);
        else chk("grant_id", acc, 128'(1) << grant_q.pop_front());
        acc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
    end
    if (req_valid != '0) begin
      chk("accept_timeout", req_valid, 0);
      req_valid = '0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 3000;
    while ((exp_q.size() != 0 || rsp_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete(); acc_q.delete(); grant_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_batch(input logic [NREQ-1:0] set);
    issue_batch(set);
    drain();
  endtask

  task automatic one(input int id, input logic [9:0] sc, input logic [63:0] m);
    b_scale[id] = sc;
    b_mant[id]  = m;
    run_batch(NREQ'(1) << id);
  endtask

  initial begin
    logic [NREQ-1:0] s;
    int              id;
    rst_n = 1'b1;
    req_valid = '0;
    req_scale = '0;
    req_mant  = '0;
    for (int i = 0; i < NREQ; i++) begin
      b_scale[i] = '0;
      b_mant[i]  = '0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_rst_n", eng_rst_n, 0);
    chk("rst_rsp_data", {rsp_id, rsp_scale, rsp_mant, rsp_shift, rsp_zero, rsp_timeout}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("eng_rst_n_released", eng_rst_n, 1);

    // All four requesting from reset, then requester 0 again.
    for (int i = 0; i < NREQ; i++) begin
      b_mant[i]  = rand_mant() | 64'h1;
      b_scale[i] = 10'($urandom);
    end
    run_batch(4'b1111);
    one(0, 10'($urandom), rand_mant());

    one(0, 10'd5, 64'h4000_0000_0000_0000);
    one(2, 10'd0, 64'h8000_0000_0000_0000);
    one(2, 10'd0, 64'h1);
    one(1, 10'd7, 64'h0);
    one(3, 10'd9, 64'h0);

    // Hung engine, then a normal request.
    eng_mode = M_HANG;
    one($urandom_range(0, NREQ - 1), 10'($urandom), 64'h0000_0100_0000_0000);
    eng_mode = M_NORM;
    one($urandom_range(0, NREQ - 1), 10'($urandom), 64'h0000_0100_0000_0000);
    // Done arriving in the very cycle the watchdog expires.
    eng_mode = M_EXP;
    one(1, 10'd3, 64'h0123_4567_89ab_cdef);
    eng_mode = M_NORM;

    // Consumer stalls for 10 cycles while another requester waits.
    stall_next = 1;
    for (int i = 0; i < NREQ; i++) begin
      b_mant[i]  = rand_mant();
      b_scale[i] = 10'($urandom);
    end
    run_batch(4'b0101);

    rand_rdy = 1;
    for (int b = 0; b < 40; b++) begin
      s = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        b_mant[i]  = rand_mant();
        b_scale[i] = 10'($urandom);
      end
      run_batch(s);
    end
    rand_rdy = 0;

    // Reset while the engine is busy.
    id = $urandom_range(0, NREQ - 1);
    b_mant[id]  = 64'h1;
    b_scale[id] = 10'd0;
    issue_batch(NREQ'(1) << id);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_eng_start", eng_start, 0);
    chk("midrst_eng_rst_n", eng_rst_n, 0);
    chk("midrst_eng_regs", {eng_scale_in, eng_mant_prod}, 0);
    chk("midrst_req_ready", req_ready, 0);
    exp_q.delete(); acc_q.delete(); grant_q.delete();
    model_lg = NREQ - 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      b_mant[i]  = rand_mant() | 64'h1;
      b_scale[i] = 10'($urandom);
    end
    run_batch(4'b1011);

    repeat (3) @(posedge clk);
    chk("start_count", starts, exp_starts);
    chk("kill_count", kills, exp_kills);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "global timeout");
  end

endmodule
